jtag_sequencer: RTL and testbench

JTAG_SEQUENCER -- requirements
Module: jtag_sequencer

---
 rtl/jtag_sequencer.sv | 173 +++++++++++++++++
 tb/tb_jtag_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_sequencer.sv
// JTAG TAP sequencer: turns reset/IR/DR/idle commands into registered
// TMS/TDI streams and returns the TDO bits captured while shifting.
module jtag_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic                      tck,
   input  logic                      trst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [$clog2(DATA_W)-1:0] cmd_len,
   input  logic [DATA_W-1:0]         cmd_data,
   output logic                      tms,
   output logic                      tdi,
   input  logic                      tdo,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_data
);

   localparam int LW = $clog2(DATA_W);

   localparam logic [1:0] OP_TLR  = 2'b00;
   localparam logic [1:0] OP_IR   = 2'b01;
   localparam logic [1:0] OP_DR   = 2'b10;
   localparam logic [1:0] OP_IDLE = 2'b11;

   typedef enum logic [3:0] {
      TLR_SEQ, READY, SEL_DR, SEL_IR, CAPTURE,
      SHIFT, UPDATE, RTI_RET, IDLE_RUN
   } state_e;

   state_e              state_q, state_d;
   logic [LW-1:0]       cnt_q, cnt_d;
   logic [1:0]          op_q;
   logic [LW-1:0]       len_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   cap_q, cap_d;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_valid_q;
   logic                tms_q, tms_d;
   logic                tdi_q, tdi_d;
   logic                busy_q;
   logic                accept;
   logic                done;

   // The state names the bit currently on TMS, so cnt counts within a state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         TLR_SEQ: begin
            if (cnt_q == LW'(5)) begin
               state_d = READY;
               cnt_d   = '0;
               done    = busy_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         READY: begin
            if (cmd_valid) begin
               accept = 1'b1;
               cnt_d  = '0;
               unique case (cmd_op)
                  OP_TLR:       state_d = TLR_SEQ;
                  OP_IDLE:      state_d = IDLE_RUN;
                  OP_IR, OP_DR: state_d = SEL_DR;
               endcase
            end
         end
         SEL_DR: state_d = (op_q == OP_IR) ? SEL_IR : CAPTURE;
         SEL_IR: state_d = CAPTURE;
         CAPTURE: begin
            if (cnt_q == LW'(1)) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q == len_q) begin
               state_d = UPDATE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         UPDATE: state_d = RTI_RET;
         RTI_RET: begin
            state_d = READY;
            done    = busy_q;
         end
         IDLE_RUN: begin
            if (cnt_q == len_q) begin
               state_d = READY;
               cnt_d   = '0;
               done    = busy_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = TLR_SEQ;
      endcase
   end

   always_comb begin
      tms_d = 1'b0;
      tdi_d = 1'b0;
      unique case (state_d)
         TLR_SEQ:                tms_d = (cnt_d != LW'(5));
         SEL_DR, SEL_IR, UPDATE: tms_d = 1'b1;
         SHIFT: begin
            tms_d = (cnt_d == len_q);
            tdi_d = data_q[cnt_d];
         end
         default: ;
      endcase
   end

   // Capture starts clean so bits above L read back as zero.
   always_comb begin
      cap_d = cap_q;
      if (accept) begin
         cap_d = '0;
      end else if (state_q == SHIFT) begin
         cap_d[cnt_q] = tdo;
      end
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         state_q     <= TLR_SEQ;
         cnt_q       <= '0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         cap_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         op_q        <= '0;
         len_q       <= '0;
         data_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         cap_q       <= cap_d;
         rsp_valid_q <= done;
         if (done) begin
            rsp_data_q <= cap_q;
         end
         if (accept) begin
            op_q   <= cmd_op;
            len_q  <= cmd_len;
            data_q <= cmd_data;
            busy_q <= 1'b1;
         end else if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign cmd_ready = (state_q == READY);
   assign tms       = tms_q;
   assign tdi       = tdi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_sequencer.sv
// Bench for jtag_sequencer: a TAP test-logic model plus a command-level
// reference model feeding bit and response scoreboards.
module tb_jtag_sequencer;

   localparam int          W        = 32;
   localparam logic [3:0]  IDCODE_I = 4'h9;
   localparam logic [3:0]  BYPASS_I = 4'hF;
   localparam logic [31:0] IDCODE   = 32'h1BAD_C0DF;
   localparam logic [31:0] USER_CAP = 32'hA5A5_0F0F;

   logic        tck = 1'b0;
   logic        trst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [4:0]  cmd_len = '0;
   logic [31:0] cmd_data = '0;
   logic        tms;
   logic        tdi;
   logic        tdo;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   jtag_sequencer #(.DATA_W(W)) dut (
      .tck       (tck),
      .trst      (trst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data)
   );

   always #5 tck = ~tck;

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          exp_len = 0;
   bit          outstanding = 1'b0;
   bit          exp_rsp = 1'b0;
   logic [1:0]  bitq[$];
   logic [31:0] rspq[$];
   logic [3:0]  ir_m = IDCODE_I;

   always @(posedge tck) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- test logic: a standard 16-state TAP ----------------
   typedef enum int {
      T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
      T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
   } tap_e;

   tap_e        tap = T_TLR;
   logic [31:0] sr = '0;
   logic [3:0]  ir = IDCODE_I;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         T_TLR:  return m ? T_TLR  : T_RTI;
         T_RTI:  return m ? T_SDR  : T_RTI;
         T_SDR:  return m ? T_SIR  : T_CDR;
         T_CDR:  return m ? T_E1DR : T_SHDR;
         T_SHDR: return m ? T_E1DR : T_SHDR;
         T_E1DR: return m ? T_UDR  : T_PDR;
         T_PDR:  return m ? T_E2DR : T_PDR;
         T_E2DR: return m ? T_UDR  : T_SHDR;
         T_SIR:  return m ? T_TLR  : T_CIR;
         T_CIR:  return m ? T_E1IR : T_SHIR;
         T_SHIR: return m ? T_E1IR : T_SHIR;
         T_E1IR: return m ? T_UIR  : T_PIR;
         T_PIR:  return m ? T_E2IR : T_PIR;
         T_E2IR: return m ? T_UIR  : T_SHIR;
         default: return m ? T_SDR : T_RTI;
      endcase
   endfunction

   always @(posedge tck) begin
      case (tap)
         T_TLR:  ir <= IDCODE_I;
         T_CIR:  sr <= 32'h5;
         T_SHIR: sr <= {28'b0, tdi, sr[3:1]};
         T_UIR:  ir <= sr[3:0];
         T_CDR:  sr <= (ir == BYPASS_I) ? 32'h0 :
                       (ir == IDCODE_I) ? IDCODE : USER_CAP;
         T_SHDR: sr <= (ir == BYPASS_I) ? {31'b0, tdi} : {tdi, sr[31:1]};
         default: ;
      endcase
      tap <= tap_next(tap, tms);
   end

   assign tdo = (tap == T_SHIR || tap == T_SHDR) ? sr[0] : 1'b0;

   // ---------------- reference model: whole-command view ----------------
   task automatic model(input logic [1:0] op, input int L,
                        input logic [31:0] d);
      logic [63:0] s;
      logic [63:0] rsp;
      logic [31:0] cap;
      int          n;
      rsp = '0;
      if (op == 2'b00) begin
         for (int i = 0; i < 6; i++) bitq.push_back({i < 5, 1'b0});
         ir_m    = IDCODE_I;
         exp_len = 6;
      end else if (op == 2'b11) begin
         for (int i = 0; i < L; i++) bitq.push_back(2'b00);
         exp_len = L;
      end else begin
         if (op == 2'b01) begin
            n = 4; cap = 32'h5;
            bitq.push_back(2'b10); bitq.push_back(2'b10);
            bitq.push_back(2'b00); bitq.push_back(2'b00);
         end else begin
            n   = (ir_m == BYPASS_I) ? 1 : 32;
            cap = (ir_m == BYPASS_I) ? 32'h0 :
                  (ir_m == IDCODE_I) ? IDCODE : USER_CAP;
            bitq.push_back(2'b10);
            bitq.push_back(2'b00); bitq.push_back(2'b00);
         end
         for (int i = 0; i < L; i++) bitq.push_back({i == L - 1, d[i]});
         bitq.push_back(2'b10); bitq.push_back(2'b00);
         // chain sees the captured bits first, then the TDI bits
         s   = ({32'b0, d} << n) | {32'b0, cap};
         rsp = s & ((64'd1 << L) - 64'd1);
         if (op == 2'b01) ir_m = 4'(s >> L);
         exp_len = L + ((op == 2'b01) ? 6 : 5);
      end
      rspq.push_back(rsp[31:0]);
      exp_rsp     = 1'b1;
      outstanding = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(posedge tck) begin
      logic [1:0] e;
      #1;
      if (!trst) begin
         if (bitq.size() > 0) begin
            e = bitq.pop_front();
            chk("tms_tdi", {tms, tdi}, e);
         end else if (cmd_ready) begin
            chk("ready_idle_tms_tdi", {tms, tdi}, 2'b00);
         end
         if (rsp_valid) begin
            if (rspq.size() == 0) begin
               n_chk++;
               $display("FAIL rsp_spurious: got rsp_valid=1 expected 0");
            end else begin
               chk("rsp_data", rsp_data, rspq.pop_front());
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic wait_ready(input bit scramble);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         if (scramble) begin
            cmd_op   = 2'($urandom);
            cmd_len  = 5'($urandom);
            cmd_data = $urandom;
         end
         @(negedge tck);
         n++;
      end
      chk("ready_timeout", cmd_ready, 1'b1);
      if (outstanding) begin
         chk("rsp_with_ready", rsp_valid, exp_rsp);
         chk("latency", cyc - acc_cyc, exp_len);
         outstanding = 1'b0;
      end
   endtask

   task automatic send(input logic [1:0] op, input int L,
                       input logic [31:0] d, input bit keep);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = 5'(L - 1);
      cmd_data  = d;
      wait_ready(1'b0);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      model(op, L, d);
      acc_cyc = cyc + 1;
      @(posedge tck);
      @(negedge tck);
      if (!keep) begin
         wait_ready(1'b1);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic chk_reset();
      chk("rst_tms", tms, 1'b1);
      chk("rst_tdi", tdi, 1'b0);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 32'h0);
   endtask

   task automatic do_release();
      @(negedge tck);
      trst        = 1'b0;
      acc_cyc     = cyc;
      exp_len     = 6;
      exp_rsp     = 1'b0;
      outstanding = 1'b1;
      ir_m        = IDCODE_I;
      for (int i = 1; i < 6; i++) bitq.push_back({i < 5, 1'b0});
      wait_ready(1'b0);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] d;
      int          L;
      bit          k;
      repeat (3) @(negedge tck);
      chk_reset();
      do_release();

      send(2'b01, 4, 32'h9, 1'b0);
      send(2'b10, 32, 32'hDEAD_BEEF, 1'b0);
      send(2'b01, 4, 32'hF, 1'b0);
      send(2'b10, 1, 32'h1, 1'b0);
      send(2'b11, 3, 32'h0, 1'b1);
      send(2'b10, 8, $urandom, 1'b0);
      send(2'b00, 1, 32'h0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         L  = $urandom_range(1, 32);
         d  = $urandom;
         if (op == 2'b01 && $urandom_range(0, 1) == 1)
            d = $urandom_range(0, 1) == 1 ? 32'h9 : 32'hF;
         k  = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
         send(op, L, d, k);
         if (!k) repeat ($urandom_range(0, 2)) @(negedge tck);
      end

      send(2'b00, 1, 32'h0, 1'b0);
      send(2'b10, 32, $urandom, 1'b0);

      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_len   = 5'd31;
      cmd_data  = $urandom;
      wait_ready(1'b0);
      model(2'b10, 32, cmd_data);
      acc_cyc = cyc + 1;
      @(posedge tck);
      @(negedge tck);
      cmd_valid = 1'b0;
      repeat (13) @(posedge tck);
      #2;
      trst = 1'b1;
      bitq.delete();
      rspq.delete();
      outstanding = 1'b0;
      #1;
      chk_reset();
      repeat (2) @(negedge tck);
      chk_reset();
      do_release();

      send(2'b10, 32, $urandom, 1'b0);
      repeat (3) @(negedge tck);
      chk("rsp_drain", rspq.size(), 0);
      chk("bits_drain", bitq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
